// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-state engine: directions, FSM states
// and 16x16 board cell arithmetic. A cell address is {x[3:0], y[3:0]}.
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_MOVE,
      ST_COMMIT,
      ST_DEAD
   } state_t;

   function automatic logic [3:0] cell_x(input logic [7:0] addr);
      return addr[7:4];
   endfunction

   function automatic logic [3:0] cell_y(input logic [7:0] addr);
      return addr[3:0];
   endfunction

   function automatic logic [7:0] cell_xy(input logic [3:0] x, input logic [3:0] y);
      return {x, y};
   endfunction

   // Opposite directions share bit 1 and differ in bit 0.
   function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

   function automatic logic [7:0] cell_next(input logic [7:0] addr, input logic [1:0] dir);
      logic [3:0] x;
      logic [3:0] y;
      x = cell_x(addr);
      y = cell_y(addr);
      case (dir)
         DIR_UP:   y = y - 4'd1;
         DIR_DOWN: y = y + 4'd1;
         DIR_LEFT: x = x - 4'd1;
         default:  x = x + 4'd1;
      endcase
      return cell_xy(x, y);
   endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer holding the snake body, tail at the read pointer.
// Push and pop in the same cycle keep the count unchanged, also when full.
module snake_body_fifo #(
   parameter int MAX_LEN = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [7:0]                 i_data,
   output logic [7:0]                 o_tail_q,
   output logic [$clog2(MAX_LEN):0]   o_count
);

   localparam int PW = $clog2(MAX_LEN);

   logic [7:0]    r_mem [MAX_LEN];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         if (i_push && !i_pop)      r_count <= r_count + (PW+1)'(1);
         else if (i_pop && !i_push) r_count <= r_count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_tail_q = r_mem[r_rd_ptr];
   assign o_count  = r_count;

endmodule

// File: rtl/snake_map_engine.sv
// Snake game-state engine: occupancy map, food register, move/grow/collide
// FSM and the display's registered per-tile lookup port.
//
// state  | meaning
// INIT   | lay down the 3-cell starting body, one cell per cycle
// IDLE   | wait for step; accept food loads onto free cells
// MOVE   | resolve direction, next head, eat and hit
// COMMIT | apply the move, or die
// DEAD   | frozen until reset
module snake_map_engine #(
   parameter int          MAX_LEN    = 64,
   parameter logic [7:0]  START_CELL = 8'h88
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic [1:0]  dir,
   input  logic        food_load,
   input  logic [7:0]  food_addr,
   input  logic [7:0]  rd_addr,
   output logic        rd_type,
   output logic [7:0]  head_addr,
   output logic [8:0]  len,
   output logic        busy,
   output logic        grow_ev,
   output logic        dead
);

   import snake_pkg::*;

   localparam int CW = $clog2(MAX_LEN) + 1;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [255:0]   r_map;
   logic [1:0]     r_cur_dir;
   logic [1:0]     r_init_cnt;
   logic [7:0]     r_food_addr;
   logic           r_food_valid;
   logic [7:0]     r_head;
   logic [7:0]     r_next_head;
   logic           r_eat;
   logic           r_hit;
   logic           r_dead;
   logic           r_grow_ev;
   logic           r_rd_type;

   logic [3:0]     w_init_x;
   logic [7:0]     w_init_cell;
   logic [1:0]     w_dir_eff;
   logic [7:0]     w_next_head;
   logic           w_eat;
   logic           w_hit;
   logic           w_full;
   logic           w_food_ok;
   logic           w_push;
   logic           w_pop;
   logic [7:0]     w_push_data;
   logic [7:0]     w_tail;
   logic [CW-1:0]  w_count;

   snake_body_fifo #(.MAX_LEN(MAX_LEN)) u_body (
      .clk      (clk),
      .rst      (rst),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_data   (w_push_data),
      .o_tail_q (w_tail),
      .o_count  (w_count)
   );

   assign w_init_x    = cell_x(START_CELL) - 4'd2 + {2'b00, r_init_cnt};
   assign w_init_cell = cell_xy(w_init_x, cell_y(START_CELL));
   assign w_dir_eff   = is_reverse(dir, r_cur_dir) ? r_cur_dir : dir;
   assign w_next_head = cell_next(r_head, w_dir_eff);
   assign w_eat       = r_food_valid && (w_next_head == r_food_addr);
   // The tail cell is vacated this move unless the snake grows.
   assign w_hit       = r_map[w_next_head] && !((w_next_head == w_tail) && !w_eat);
   assign w_full      = (w_count == CW'(MAX_LEN));
   assign w_food_ok   = food_load && !r_map[food_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_push_data = w_init_cell;
      case (r_state)
         ST_INIT: begin
            w_push = 1'b1;
            if (r_init_cnt == 2'd2) w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (step) w_state_nxt = ST_MOVE;
         end
         ST_MOVE: begin
            w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            if (r_hit) begin
               w_state_nxt = ST_DEAD;
            end else begin
               w_push      = 1'b1;
               w_push_data = r_next_head;
               w_pop       = !r_eat || w_full;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DEAD: begin
            w_state_nxt = ST_DEAD;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_map        <= '0;
         r_cur_dir    <= DIR_RIGHT;
         r_init_cnt   <= '0;
         r_food_addr  <= '0;
         r_food_valid <= 1'b0;
         r_head       <= START_CELL;
         r_next_head  <= '0;
         r_eat        <= 1'b0;
         r_hit        <= 1'b0;
         r_dead       <= 1'b0;
         r_grow_ev    <= 1'b0;
         r_rd_type    <= 1'b0;
      end else begin
         r_grow_ev <= 1'b0;
         r_rd_type <= r_map[rd_addr] | (r_food_valid & (rd_addr == r_food_addr));
         case (r_state)
            ST_INIT: begin
               r_map[w_init_cell] <= 1'b1;
               r_init_cnt         <= r_init_cnt + 2'd1;
            end
            ST_IDLE: begin
               if (!step && w_food_ok) begin
                  r_food_addr  <= food_addr;
                  r_food_valid <= 1'b1;
               end
            end
            ST_MOVE: begin
               r_cur_dir   <= w_dir_eff;
               r_next_head <= w_next_head;
               r_eat       <= w_eat;
               r_hit       <= w_hit;
            end
            ST_COMMIT: begin
               if (r_hit) begin
                  r_dead <= 1'b1;
               end else begin
                  // Clear before set so a head entering the old tail cell stays marked.
                  if (w_pop) r_map[w_tail] <= 1'b0;
                  r_map[r_next_head] <= 1'b1;
                  r_head             <= r_next_head;
                  if (r_eat) begin
                     r_grow_ev    <= 1'b1;
                     r_food_valid <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rd_type   = r_rd_type;
   assign head_addr = r_head;
   assign len       = 9'(w_count);
   assign busy      = (r_state != ST_IDLE);
   assign grow_ev   = r_grow_ev;
   assign dead      = r_dead;

endmodule

// File: tb/tb_snake_map_engine.sv
// Bench for snake_map_engine: directed scenarios plus a random walk, all
// compared against a queue-based model of the snake game rules.
module tb_snake_map_engine;

   localparam int MAX_LEN = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        step = 1'b0;
   logic [1:0]  dir = 2'b11;
   logic        food_load = 1'b0;
   logic [7:0]  food_addr = 8'h00;
   logic [7:0]  rd_addr = 8'h00;
   logic        rd_type;
   logic [7:0]  head_addr;
   logic [8:0]  len;
   logic        busy;
   logic        grow_ev;
   logic        dead;

   int n_checks = 0;
   int n_fail   = 0;

   snake_map_engine #(.MAX_LEN(MAX_LEN), .START_CELL(8'h88)) dut (
      .clk       (clk),
      .rst       (rst),
      .step      (step),
      .dir       (dir),
      .food_load (food_load),
      .food_addr (food_addr),
      .rd_addr   (rd_addr),
      .rd_type   (rd_type),
      .head_addr (head_addr),
      .len       (len),
      .busy      (busy),
      .grow_ev   (grow_ev),
      .dead      (dead)
   );

   always #5 clk = ~clk;

   // model: m_body[0] is the tail, m_body[$] the head
   logic [7:0] m_body[$];
   logic [1:0] m_dir;
   logic [7:0] m_food;
   bit         m_fv;
   bit         m_dead;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit m_occ(input logic [7:0] a);
      foreach (m_body[i]) if (m_body[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] opposite(input logic [1:0] d);
      case (d)
         2'b00:   return 2'b01;
         2'b01:   return 2'b00;
         2'b10:   return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [7:0] m_next(input logic [7:0] h, input logic [1:0] d);
      int x;
      int y;
      x = int'(h[7:4]);
      y = int'(h[3:0]);
      case (d)
         2'b00:   y = (y + 15) % 16;
         2'b01:   y = (y + 1) % 16;
         2'b10:   x = (x + 15) % 16;
         default: x = (x + 1) % 16;
      endcase
      return 8'(x * 16 + y);
   endfunction

   function automatic logic [1:0] m_eff_dir(input logic [1:0] d);
      return (d == opposite(m_dir)) ? m_dir : d;
   endfunction

   task automatic m_reset();
      m_body = {8'h68, 8'h78, 8'h88};
      m_dir  = 2'b11;
      m_food = 8'h00;
      m_fv   = 1'b0;
      m_dead = 1'b0;
   endtask

   task automatic m_step(input logic [1:0] d, output bit eat);
      logic [7:0] nh;
      eat = 1'b0;
      if (m_dead) return;
      m_dir = m_eff_dir(d);
      nh  = m_next(m_body[$], m_dir);
      eat = m_fv && (nh == m_food);
      if (m_occ(nh) && !((nh == m_body[0]) && !eat)) begin
         m_dead = 1'b1;
         eat    = 1'b0;
         return;
      end
      m_body.push_back(nh);
      if (!eat || m_body.size() > MAX_LEN) void'(m_body.pop_front());
      if (eat) m_fv = 1'b0;
   endtask

   task automatic m_food_load(input logic [7:0] a);
      if (!m_dead && !m_occ(a)) begin
         m_food = a;
         m_fv   = 1'b1;
      end
   endtask

   task automatic release_reset();
      rst = 1'b0;
      m_reset();
      check_val("busy_init_c0", busy, 1);
      for (int i = 1; i <= 2; i++) begin
         @(posedge clk); @(negedge clk);
         check_val($sformatf("busy_init_c%0d", i), busy, 1);
      end
      @(posedge clk); @(negedge clk);
      check_val("busy_after_init", busy, 0);
      check_val("len_after_init", len, 3);
      check_val("head_after_init", head_addr, 8'h88);
   endtask

   task automatic apply_reset(input bit at_once);
      if (!at_once) @(negedge clk);
      rst = 1'b1;
      step = 1'b0;
      food_load = 1'b0;
      #1;
      check_val("rst_busy", busy, 1);
      check_val("rst_len", len, 0);
      check_val("rst_dead", dead, 0);
      check_val("rst_grow", grow_ev, 0);
      check_val("rst_rd", rd_type, 0);
      check_val("rst_head", head_addr, 8'h88);
      @(negedge clk);
      release_reset();
   endtask

   task automatic do_step(input logic [1:0] d, input bit extra);
      bit eat;
      @(negedge clk);
      step = 1'b1;
      dir  = d;
      @(posedge clk); @(negedge clk);
      step = extra;
      check_val("busy_n1", busy, 1);
      check_val("grow_n1", grow_ev, 0);
      @(posedge clk); @(negedge clk);
      step = 1'b0;
      check_val("busy_n2", busy, 1);
      m_step(d, eat);
      @(posedge clk); @(negedge clk);
      check_val("grow_ev", grow_ev, eat);
      check_val("busy_done", busy, m_dead);
      check_val("head", head_addr, m_body[$]);
      check_val("len", len, m_body.size());
      check_val("dead", dead, m_dead);
   endtask

   task automatic do_food(input logic [7:0] a);
      @(negedge clk);
      food_load = 1'b1;
      food_addr = a;
      @(posedge clk); @(negedge clk);
      food_load = 1'b0;
      m_food_load(a);
   endtask

   task automatic check_cell(input logic [7:0] a);
      @(negedge clk);
      rd_addr = a;
      @(posedge clk); @(negedge clk);
      check_val($sformatf("rd_%02h", a), rd_type, m_occ(a) || (m_fv && a == m_food));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] d;
      int r;

      repeat (2) @(negedge clk);
      apply_reset(1'b1);
      check_cell(8'h68);
      check_cell(8'h78);
      check_cell(8'h88);
      check_cell(8'h98);

      do_step(2'b11, 1'b0);
      check_val("rev_first", head_addr, 8'h98);
      do_step(2'b10, 1'b0);
      check_val("rev_ignored", head_addr, 8'hA8);
      check_cell(8'h78);
      check_val("rev_len", len, 3);

      do_food(8'hB8);
      do_step(2'b11, 1'b0);
      check_val("food_len", len, 4);
      check_cell(8'hB8);
      check_cell(8'h88);

      do_food(8'h98);
      do_step(2'b11, 1'b0);
      do_step(2'b11, 1'b0);
      check_cell(8'h98);
      check_val("food_rejected", rd_type, 0);

      do_step(2'b11, 1'b0);
      do_step(2'b11, 1'b0);
      check_val("at_x15", head_addr, 8'hF8);
      do_step(2'b11, 1'b0);
      check_val("wrap_head", head_addr, 8'h08);
      check_val("wrap_alive", dead, 0);

      do_food(8'h18);
      do_step(2'b11, 1'b0);
      check_val("grow5_len", len, 5);
      do_step(2'b00, 1'b0);
      do_step(2'b10, 1'b0);
      do_step(2'b01, 1'b0);
      check_val("collide_dead", dead, 1);
      check_val("collide_head", head_addr, 8'h07);
      do_food(8'h37);
      do_step(2'b00, 1'b0);
      check_val("frozen_head", head_addr, 8'h07);
      check_val("frozen_len", len, 5);
      check_cell(8'h37);
      check_cell(8'h08);

      apply_reset(1'b0);
      do_food(8'h98);
      do_step(2'b11, 1'b0);
      check_val("chase_len", len, 4);
      for (int k = 0; k < 2; k++) begin
         do_step(2'b00, 1'b0);
         do_step(2'b10, 1'b0);
         do_step(2'b01, 1'b0);
         do_step(2'b11, 1'b0);
      end
      check_val("chase_alive", dead, 0);
      check_cell(8'h88);

      apply_reset(1'b0);
      do_step(2'b01, 1'b1);
      check_val("busy_drop_head", head_addr, 8'h89);

      @(negedge clk);
      step = 1'b1;
      dir  = 2'b11;
      @(posedge clk); @(negedge clk);
      step = 1'b0;
      @(posedge clk); @(negedge clk);
      apply_reset(1'b1);
      check_cell(8'h98);

      for (int it = 0; it < 150; it++) begin
         if (m_dead) apply_reset(1'b0);
         r = int'($urandom_range(0, 9));
         d = 2'($urandom_range(0, 3));
         if (r < 3) begin
            do_food(m_next(m_body[$], m_eff_dir(d)));
            do_step(d, 1'b0);
         end else if (r == 3) begin
            do_food(8'($urandom_range(0, 255)));
         end else begin
            do_step(d, r == 9);
         end
         if (r[0]) check_cell(8'($urandom_range(0, 255)));
         else      check_cell(m_body[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
